mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
//
// PURPOSE
// Iterative multiply sequencer for the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
// It accepts an operand pair and a one-hot op select over a valid/ready handshake.
// It runs a radix-2 shift-add over WIDTH cycles and applies the signed correction.
// It holds the 32-bit selected result until the consumer takes it.
// It sits beside the single-cycle ALU, so the core issues multiplies here instead of using a combinational multiplier.
//
// PARAMETERS
// WIDTH   32   operand/result width; internal product register is 2*WIDTH
//
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      synchronous, active-high reset
// flush          in   1      abort any in-flight op; synchronous
// start_valid    in   1      request present
// start_ready    out  1      sequencer can accept a request this cycle
// operand_a      in   WIDTH  multiplicand (rs1)
// operand_b      in   WIDTH  multiplier (rs2)
// op_mul         in   1      select MUL    (low WIDTH bits)
// op_mulh        in   1      select MULH   (high bits, signed x signed)
// op_mulhsu      in   1      select MULHSU (high bits, signed a x unsigned b)
// op_mulhu       in   1      select MULHU  (high bits, unsigned x unsigned)
// result_valid   out  1      result is held and valid
// result_ready   in   1      consumer takes result
// result         out  WIDTH  selected product half
// busy           out  1      state != IDLE
//
// BEHAVIOUR
// - States: IDLE, CALC, FIX, DONE. Reset drives state to IDLE.
// - Reset values: result=0, result_valid=0, busy=0, start_ready=1, and all internal registers cleared.
// - start_ready = (IDLE) | (DONE & result_ready). Acceptance occurs when start_valid & start_ready are high at a clock edge.
// - On accept, the block latches the op, the sign flags and the operand magnitudes:
//   - a is signed for MULH and MULHSU.
//   - b is signed for MULH only.
//   - For a signed operand, magnitude = two's-complement abs. abs(0x80000000) = 0x80000000, treated as unsigned.
// - The op select is one-hot. If several selects are high, priority is MUL > MULH > MULHSU > MULHU.
//   If none is high, the request is still accepted and produces result=0 with normal latency.
// - MUL ignores signs, because the low half is sign-independent.
// - CALC lasts exactly WIDTH cycles, one multiplier bit per cycle.
//   - Each cycle: if the multiplier LSB is set, add the multiplicand into the upper half.
//   - Then shift the 2*WIDTH accumulator right by 1, keeping the carry.
//   - A 5-bit (clog2 WIDTH) counter counts 0..WIDTH-1. On count==WIDTH-1, go to FIX.
// - FIX lasts 1 cycle. If sign_a XOR sign_b (as qualified by op), negate the full 2*WIDTH product.
//   It then selects the low half for MUL or the high half otherwise, registers it into result, and goes to DONE.
// - Latency: result_valid first goes high exactly WIDTH+1 cycles after the acceptance edge (33 cycles for WIDTH=32). There is no early-out.
// - DONE: result_valid=1 and result is stable until a cycle in which result_ready=1.
//   - On that edge, with start_valid=1: accept the new request and go to CALC (back-to-back, no IDLE bubble).
//   - On that edge, with start_valid=0: go to IDLE.
// - result retains its last value after handoff. Consumers qualify it with result_valid only.
// - flush takes precedence over everything except rst:
//   - State goes to IDLE next edge. result_valid=0 next cycle. Any result held in DONE is discarded.
//   - A start_valid in the same cycle as flush is not accepted (start_ready is forced low while flush=1).
// - rst mid-operation has the same effect as flush and also clears result to 0.
// - Operand and op inputs are don't-care outside the acceptance cycle.
//
// TESTING (WIDTH=32)
// 1. MUL a=7, b=6 -> result=0x0000002A; result_valid rises 33 cycles after accept.
// 2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
// 3. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE.
// 4. Backpressure: result_ready=0 for 10 cycles in DONE -> result and result_valid stay stable.
//    Then raise result_ready with start_valid=1 (MUL 3x5) -> handoff and accept on the same edge; next result is 0x0000000F.
// 5. flush asserted in CALC cycle 10 -> IDLE next cycle, result_valid never rises.
//    A fresh MUL 2x2 then returns 0x00000004 with full 33-cycle latency.
// 6. rst asserted in DONE with result pending -> result_valid=0 and result=0 next cycle, start_ready=1.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Radix-2 shift-add sequencer for MUL/MULH/MULHSU/MULHU with
//               valid/ready request and result handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             op_mul,
  input  logic             op_mulh,
  input  logic             op_mulhsu,
  input  logic             op_mulhu,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int                c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;

  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_neg;
  logic                 r_sel_high;
  logic [WIDTH-1:0]     r_result;

  // Priority-qualified sign handling; MUL forces both operands unsigned.
  logic                 w_any_op;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_mcand;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [2*WIDTH-1:0]   w_prod_fix;

  assign w_any_op   = op_mul | op_mulh | op_mulhsu | op_mulhu;
  assign w_sign_a   = ~op_mul & (op_mulh | op_mulhsu) & operand_a[WIDTH-1];
  assign w_sign_b   = ~op_mul & op_mulh & operand_b[WIDTH-1];
  assign w_mag_a    = w_sign_a ? (-operand_a) : operand_a;
  assign w_mag_b    = w_sign_b ? (-operand_b) : operand_b;
  // No op selected: a zero multiplicand yields a zero result at normal latency.
  assign w_mcand    = w_any_op ? w_mag_a : '0;

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
  assign w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod_fix = r_neg ? (-r_acc) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    start_ready  = ~flush & ((r_state == IDLE) | ((r_state == DONE) & result_ready));
    w_accept     = start_valid & start_ready;
    result_valid = (r_state == DONE);
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (r_cnt == c_cnt_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (result_ready) w_state_nxt = w_accept ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_sel_high <= 1'b0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_acc      <= {{WIDTH{1'b0}}, w_mag_b};
      r_mcand    <= w_mcand;
      r_cnt      <= '0;
      r_neg      <= w_sign_a ^ w_sign_b;
      r_sel_high <= ~op_mul;
    end else if (!flush && r_state == CALC) begin
      r_acc      <= w_acc_step;
      r_cnt      <= r_cnt + c_cnt_w'(1);
    end else if (!flush && r_state == FIX) begin
      r_result   <= r_sel_high ? w_prod_fix[2*WIDTH-1:WIDTH] : w_prod_fix[WIDTH-1:0];
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl against a 64-bit
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        op_mul;
  logic        op_mulh;
  logic        op_mulhsu;
  logic        op_mulhu;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp;
  int n_err;

  mul_seq_ctrl #(.WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .op_mul       (op_mul),
    .op_mulh      (op_mulh),
    .op_mulhsu    (op_mulhsu),
    .op_mulhu     (op_mulhu),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ops = {mul, mulh, mulhsu, mulhu}; highest set bit wins.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] ops);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    if (ops[3]) begin
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
    end else if (ops[2]) begin
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
    end else if (ops[1]) begin
      x = {{32{a[31]}}, a};
      y = {32'b0, b};
    end else if (ops[0]) begin
      x = {32'b0, a};
      y = {32'b0, b};
    end else begin
      return 32'h0;
    end
    p = x * y;
    return p[63:32];
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ops);
    start_valid = 1'b1;
    operand_a   = a;
    operand_b   = b;
    {op_mul, op_mulh, op_mulhsu, op_mulhu} = ops;
  endtask

  task automatic scramble_inputs();
    start_valid = 1'b0;
    operand_a   = $urandom;
    operand_b   = $urandom;
    {op_mul, op_mulh, op_mulhsu, op_mulhu} = 4'($urandom);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ops);
    drive_req(a, b, ops);
    @(posedge clk); #1;
    scramble_inputs();
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!result_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_result"}, {32'b0, result}, {32'b0, exp});
  endtask

  task automatic release_result(input int hold);
    logic [31:0] held;
    int          bad;
    held = result;
    bad  = 0;
    result_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (result !== held || result_valid !== 1'b1) bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("idle_after_handoff", {63'b0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    result_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_result", {32'b0, result}, 64'd0);
    check("rst_result_valid", {63'b0, result_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_start_ready", {63'b0, start_ready}, 64'd1);

    // Directed arithmetic corner cases
    start_op(32'd7, 32'd6, 4'b1000);
    check("calc_busy", {63'b0, busy}, 64'd1);
    check("calc_not_ready", {63'b0, start_ready}, 64'd0);
    wait_result("mul_7x6", 32'h0000_002A);
    release_result(0);
    start_op(32'h8000_0000, 32'h8000_0000, 4'b0100);
    wait_result("mulh_min", 32'h4000_0000);
    release_result(1);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100);
    wait_result("mulh_m1", 32'h0000_0000);
    release_result(0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010);
    wait_result("mulhsu_m1", 32'hFFFF_FFFF);
    release_result(0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001);
    wait_result("mulhu_max", 32'hFFFF_FFFE);
    release_result(0);

    // Backpressure then back-to-back handoff/accept
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b0001);
    wait_result("bp_first", model(32'h1234_5678, 32'h9ABC_DEF0, 4'b0001));
    begin
      logic [31:0] held;
      int          bad;
      held = result;
      bad  = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (result !== held || result_valid !== 1'b1) bad++;
      end
      check("bp_stable", 64'(bad), 64'd0);
    end
    result_ready = 1'b1;
    drive_req(32'd3, 32'd5, 4'b1000);
    #1;
    check("b2b_start_ready", {63'b0, start_ready}, 64'd1);
    @(posedge clk); #1;
    result_ready = 1'b0;
    scramble_inputs();
    check("b2b_valid_drop", {63'b0, result_valid}, 64'd0);
    check("b2b_busy", {63'b0, busy}, 64'd1);
    wait_result("b2b_mul_3x5", 32'h0000_000F);
    release_result(0);

    // Flush mid-calculation
    start_op(32'hDEAD_BEEF, 32'h0000_1234, 4'b1000);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    drive_req(32'd9, 32'd9, 4'b1000);
    #1;
    check("flush_blocks_ready", {63'b0, start_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    scramble_inputs();
    check("flush_idle", {63'b0, busy}, 64'd0);
    begin
      int rises;
      rises = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (result_valid) rises++;
      end
      check("flush_no_valid", 64'(rises), 64'd0);
    end
    start_op(32'd2, 32'd2, 4'b1000);
    wait_result("post_flush_2x2", 32'h0000_0004);
    release_result(0);

    // Reset while a result is pending
    start_op(32'hCAFE_0001, 32'h0000_0003, 4'b1000);
    wait_result("pre_rst", model(32'hCAFE_0001, 32'h0000_0003, 4'b1000));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_valid", {63'b0, result_valid}, 64'd0);
    check("rst_done_result", {32'b0, result}, 64'd0);
    check("rst_done_ready", {63'b0, start_ready}, 64'd1);

    // Randomized ops, including multi-hot and no-select encodings
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ops;
      a   = pick_operand();
      b   = pick_operand();
      ops = 4'($urandom_range(0, 15));
      start_op(a, b, ops);
      wait_result($sformatf("rand%0d_ops%b", k, ops), model(a, b, ops));
      release_result($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
